// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control constants: ALU codes, opcodes, operand selects,
// immediate types, decode-stage occupancy states and the decoded word.
package riscv_ctrl_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLL  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SUB  = 4'd12;
   localparam logic [3:0] ALU_SRA  = 4'd13;
   localparam logic [3:0] ALU_BSEL = 4'd15;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic A_SEL_RS1 = 1'b0;
   localparam logic A_SEL_PC  = 1'b1;
   localparam logic B_SEL_RS2 = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [3:0]  alu_sel;
      logic        a_sel;
      logic        b_sel;
      logic        illegal;
   } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator, sign-extended to XLEN.
// Ports: inst (instruction word), imm_type (I/S/B/U/J or none), imm (result).
module imm_gen
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_type,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                         inst[30:25], inst[11:8], 1'b0};
         IMM_U: imm32 = {inst[31:12], 12'b0};
         IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                         inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Signed source makes the width cast sign-extend for XLEN > 32.
   assign imm = XLEN'(imm32);

endmodule

// File: rtl/alu_op_decode.sv
// RV32I decode stage: builds the ALU control word and immediate, then
// holds it in an output register plus a skid entry so in_ready is a flop.
// Ports: clk, rst_n (sync, low); in_valid/in_ready/in_inst/in_pc upstream;
// flush; out_valid/out_ready, alu_sel, a_sel, b_sel, imm, illegal,
// out_inst, out_pc toward execute.
module alu_op_decode
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_sel,
   output logic            a_sel,
   output logic            b_sel,
   output logic [XLEN-1:0] imm,
   output logic            illegal,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc
);

   // ---------------- decode ----------------
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = in_inst[6:0];
   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];

   logic is_op, is_opimm, is_lui, is_auipc;
   logic is_jal, is_jalr, is_load, is_store, is_branch;

   assign is_op     = (opc == OPC_OP);
   assign is_opimm  = (opc == OPC_OP_IMM);
   assign is_lui    = (opc == OPC_LUI);
   assign is_auipc  = (opc == OPC_AUIPC);
   assign is_jal    = (opc == OPC_JAL);
   assign is_jalr   = (opc == OPC_JALR);
   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign is_branch = (opc == OPC_BRANCH);

   logic [3:0]      dec_alu;
   logic            dec_a;
   logic            dec_b;
   logic            dec_ill;
   imm_type_e       dec_imm_type;
   logic [XLEN-1:0] dec_imm;
   ctrl_t           dec_ctrl;

   always_comb begin
      dec_alu      = ALU_ADD;
      dec_a        = A_SEL_RS1;
      dec_b        = B_SEL_RS2;
      dec_ill      = 1'b0;
      dec_imm_type = IMM_NONE;
      unique case (1'b1)
         is_op: begin
            if (f7 == 7'b0000000) begin
               dec_alu = {1'b0, f3};
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               dec_alu = ALU_SUB;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
               dec_alu = ALU_SRA;
            end else begin
               dec_ill = 1'b1;
            end
         end
         is_opimm: begin
            dec_alu      = {1'b0, f3};
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_I;
            if (f3 == 3'b001 && f7 != 7'b0) begin
               dec_ill = 1'b1;
            end
            // inst[30] picks SRAI; every other shamt-upper bit must be 0.
            if (f3 == 3'b101) begin
               if (in_inst[31] || (|in_inst[29:25])) begin
                  dec_ill = 1'b1;
               end else if (in_inst[30]) begin
                  dec_alu = ALU_SRA;
               end
            end
         end
         is_lui: begin
            dec_alu      = ALU_BSEL;
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_U;
         end
         is_auipc: begin
            dec_a        = A_SEL_PC;
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_U;
         end
         is_jal: begin
            dec_a        = A_SEL_PC;
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_J;
         end
         is_jalr, is_load: begin
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_I;
         end
         is_store: begin
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_S;
         end
         is_branch: begin
            dec_a        = A_SEL_PC;
            dec_b        = B_SEL_IMM;
            dec_imm_type = IMM_B;
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase
      // Illegal encodings carry a neutral control word.
      if (dec_ill) begin
         dec_alu      = ALU_ADD;
         dec_a        = A_SEL_RS1;
         dec_b        = B_SEL_RS2;
         dec_imm_type = IMM_NONE;
      end
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst     (in_inst),
      .imm_type (dec_imm_type),
      .imm      (dec_imm)
   );

   always_comb begin
      dec_ctrl         = '0;
      dec_ctrl.inst    = in_inst;
      dec_ctrl.alu_sel = dec_alu;
      dec_ctrl.a_sel   = dec_a;
      dec_ctrl.b_sel   = dec_b;
      dec_ctrl.illegal = dec_ill;
   end

   // ---------------- occupancy FSM ----------------
   occ_e state_q, state_d;
   logic in_ready_q, in_ready_d;
   logic accept, consume;

   assign accept  = in_valid & in_ready_q;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
               if (accept && !consume) state_d = ST_TWO;
               else if (!accept && consume) state_d = ST_EMPTY;
            end
            ST_TWO: if (consume) state_d = ST_ONE;
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d = (state_d != ST_TWO);
   end

   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = in_ready_q;
   end

   // ---------------- data registers ----------------
   ctrl_t           out_ctrl_q, out_ctrl_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   ctrl_t           skid_ctrl_q, skid_ctrl_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;

   always_comb begin
      out_ctrl_d  = out_ctrl_q;
      out_imm_d   = out_imm_q;
      out_pc_d    = out_pc_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_imm_d  = skid_imm_q;
      skid_pc_d   = skid_pc_q;
      if (!flush) begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  out_ctrl_d = dec_ctrl;
                  out_imm_d  = dec_imm;
                  out_pc_d   = in_pc;
               end
            end
            ST_ONE: begin
               // With a consume the output slot frees up this edge.
               if (accept && consume) begin
                  out_ctrl_d = dec_ctrl;
                  out_imm_d  = dec_imm;
                  out_pc_d   = in_pc;
               end else if (accept) begin
                  skid_ctrl_d = dec_ctrl;
                  skid_imm_d  = dec_imm;
                  skid_pc_d   = in_pc;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  out_ctrl_d = skid_ctrl_q;
                  out_imm_d  = skid_imm_q;
                  out_pc_d   = skid_pc_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_ctrl_q  <= '0;
         out_imm_q   <= '0;
         out_pc_q    <= '0;
         skid_ctrl_q <= '0;
         skid_imm_q  <= '0;
         skid_pc_q   <= '0;
      end else begin
         out_ctrl_q  <= out_ctrl_d;
         out_imm_q   <= out_imm_d;
         out_pc_q    <= out_pc_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_imm_q  <= skid_imm_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

   assign alu_sel  = out_ctrl_q.alu_sel;
   assign a_sel    = out_ctrl_q.a_sel;
   assign b_sel    = out_ctrl_q.b_sel;
   assign illegal  = out_ctrl_q.illegal;
   assign out_inst = out_ctrl_q.inst;
   assign imm      = out_imm_q;
   assign out_pc   = out_pc_q;

endmodule

// File: tb/tb_alu_op_decode.sv
// Directed bench for alu_op_decode: reset, per-opcode decode,
// back-pressure ordering, flush and mid-stream reset.
module tb_alu_op_decode;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_sel;
   logic        a_sel;
   logic        b_sel;
   logic [31:0] imm;
   logic        illegal;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   int n_cmp = 0;
   int n_bad = 0;

   alu_op_decode #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_sel   (alu_sel),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .imm       (imm),
      .illegal   (illegal),
      .out_inst  (out_inst),
      .out_pc    (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [3:0]  alu;
      logic        a;
      logic        b;
      logic        ill;
      logic [31:0] imm;
      logic [3:0]  chk;
   } vec_t;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready got %0b exp 0", in_ready); end
      n_cmp++; if (alu_sel !== 4'd0) begin n_bad++; $display("FAIL reset alu_sel got %0d exp 0", alu_sel); end
      n_cmp++; if (imm !== 32'd0) begin n_bad++; $display("FAIL reset imm got %h exp 0", imm); end
      n_cmp++; if (out_inst !== 32'd0) begin n_bad++; $display("FAIL reset out_inst got %h exp 0", out_inst); end
      n_cmp++; if (out_pc !== 32'd0) begin n_bad++; $display("FAIL reset out_pc got %h exp 0", out_pc); end
      n_cmp++; if ({a_sel, b_sel, illegal} !== 3'b000) begin n_bad++; $display("FAIL reset sel/ill got %b exp 000", {a_sel, b_sel, illegal}); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release in_ready got %0b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release out_valid got %0b exp 0", out_valid); end
   endtask

   // chk: [0] alu_sel, [1] a_sel, [2] b_sel, [3] imm
   task automatic test_decode();
      vec_t v [16];
      logic [31:0] pc;
      v[0]  = '{32'h002081B3, 4'd0,  1'b0, 1'b0, 1'b0, 32'h0,        4'b0111};
      v[1]  = '{32'h402081B3, 4'd12, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0111};
      v[2]  = '{32'h4020D1B3, 4'd13, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0111};
      v[3]  = '{32'h0020C1B3, 4'd4,  1'b0, 1'b0, 1'b0, 32'h0,        4'b0111};
      v[4]  = '{32'h022081B3, 4'd0,  1'b0, 1'b0, 1'b1, 32'h0,        4'b0000};
      v[5]  = '{32'h123452B7, 4'd15, 1'b0, 1'b1, 1'b0, 32'h12345000, 4'b1101};
      v[6]  = '{32'hFFF00093, 4'd0,  1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b1111};
      v[7]  = '{32'h4030D093, 4'd13, 1'b0, 1'b1, 1'b0, 32'h00000403, 4'b1111};
      v[8]  = '{32'h02009093, 4'd0,  1'b0, 1'b0, 1'b1, 32'h0,        4'b0000};
      v[9]  = '{32'h00001097, 4'd0,  1'b1, 1'b1, 1'b0, 32'h00001000, 4'b1111};
      v[10] = '{32'h008000EF, 4'd0,  1'b1, 1'b1, 1'b0, 32'h00000008, 4'b1111};
      v[11] = '{32'hFE20AE23, 4'd0,  1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 4'b1111};
      v[12] = '{32'hFE208CE3, 4'd0,  1'b1, 1'b1, 1'b0, 32'hFFFFFFF8, 4'b1111};
      v[13] = '{32'h00412083, 4'd0,  1'b0, 1'b1, 1'b0, 32'h00000004, 4'b1111};
      v[14] = '{32'hFF008067, 4'd0,  1'b0, 1'b1, 1'b0, 32'hFFFFFFF0, 4'b1111};
      v[15] = '{32'h0000007F, 4'd0,  1'b0, 1'b0, 1'b1, 32'h0,        4'b1111};
      for (int i = 0; i < 16; i++) begin
         pc = 32'h1000 + 32'(i) * 4;
         in_valid = 1'b1; in_inst = v[i].inst; in_pc = pc; out_ready = 1'b1;
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dec[%0d] in_ready got %0b exp 1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dec[%0d] out_valid got %0b exp 1", i, out_valid); end
         n_cmp++; if (out_inst !== v[i].inst) begin n_bad++; $display("FAIL dec[%0d] out_inst got %h exp %h", i, out_inst, v[i].inst); end
         n_cmp++; if (out_pc !== pc) begin n_bad++; $display("FAIL dec[%0d] out_pc got %h exp %h", i, out_pc, pc); end
         n_cmp++; if (illegal !== v[i].ill) begin n_bad++; $display("FAIL dec[%0d] illegal got %0b exp %0b", i, illegal, v[i].ill); end
         if (v[i].chk[0]) begin
            n_cmp++; if (alu_sel !== v[i].alu) begin n_bad++; $display("FAIL dec[%0d] alu_sel got %0d exp %0d", i, alu_sel, v[i].alu); end
         end
         if (v[i].chk[1]) begin
            n_cmp++; if (a_sel !== v[i].a) begin n_bad++; $display("FAIL dec[%0d] a_sel got %0b exp %0b", i, a_sel, v[i].a); end
         end
         if (v[i].chk[2]) begin
            n_cmp++; if (b_sel !== v[i].b) begin n_bad++; $display("FAIL dec[%0d] b_sel got %0b exp %0b", i, b_sel, v[i].b); end
         end
         if (v[i].chk[3]) begin
            n_cmp++; if (imm !== v[i].imm) begin n_bad++; $display("FAIL dec[%0d] imm got %h exp %h", i, imm, v[i].imm); end
         end
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dec[%0d] drain out_valid got %0b exp 0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ia, ib, ic;
      ia = 32'h002081B3; ib = 32'h402081B3; ic = 32'h0020C1B3;
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = ia; in_pc = 32'h3000;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp after A in_ready got %0b exp 1", in_ready); end
      in_inst = ib; in_pc = 32'h3004;
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp after B in_ready got %0b exp 0", in_ready); end
      n_cmp++; if (out_inst !== ia) begin n_bad++; $display("FAIL bp head got %h exp %h", out_inst, ia); end
      in_inst = ic; in_pc = 32'h3008;
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp C held in_ready got %0b exp 0", in_ready); end
      n_cmp++; if (out_inst !== ia || alu_sel !== 4'd0 || out_pc !== 32'h3000) begin n_bad++; $display("FAIL bp stable got %h/%0d/%h exp %h/0/3000", out_inst, alu_sel, out_pc, ia); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_inst !== ib || alu_sel !== 4'd12) begin n_bad++; $display("FAIL bp second got v%0b %h/%0d exp v1 %h/12", out_valid, out_inst, alu_sel, ib); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp reopen in_ready got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_inst !== ic || alu_sel !== 4'd4 || out_pc !== 32'h3008) begin n_bad++; $display("FAIL bp third got v%0b %h/%0d/%h exp v1 %h/4/3008", out_valid, out_inst, alu_sel, out_pc, ic); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp drain out_valid got %0b exp 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 32'h4000;
      tick();
      in_inst = 32'hFFF00093; in_pc = 32'h4004;
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush precond in_ready got %0b exp 0", in_ready); end
      in_inst = 32'h4030D093; in_pc = 32'h4008; flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush out_valid got %0b exp 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush in_ready got %0b exp 1", in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush stale[%0d] out_valid got %0b exp 0 inst %h", k, out_valid, out_inst); end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 32'h5000;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst precond out_valid got %0b exp 1", out_valid); end
      rst_n = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mrst v/rdy got %0b/%0b exp 0/0", out_valid, in_ready); end
      n_cmp++; if (alu_sel !== 4'd0 || imm !== 32'd0 || out_inst !== 32'd0 || out_pc !== 32'd0) begin n_bad++; $display("FAIL mrst fields got %0d/%h/%h/%h exp 0", alu_sel, imm, out_inst, out_pc); end
      n_cmp++; if ({a_sel, b_sel, illegal} !== 3'b000) begin n_bad++; $display("FAIL mrst sel/ill got %b exp 000", {a_sel, b_sel, illegal}); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst release v/rdy got %0b/%0b exp 0/1", out_valid, in_ready); end
      in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h80; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_sel !== 4'd0) begin n_bad++; $display("FAIL mrst zero-inst got v%0b ill%0b alu%0d exp v1 ill1 alu0", out_valid, illegal, alu_sel); end
      n_cmp++; if (out_pc !== 32'h80 || imm !== 32'd0) begin n_bad++; $display("FAIL mrst zero-inst pc/imm got %h/%h exp 80/0", out_pc, imm); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst drain out_valid got %0b exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
